// File: rtl/spi_ram_burst.sv
// SPI slave with an integrated single-port RAM: 2-bit command, address field, then
// back-to-back burst data words with an auto-incrementing pointer. clk is the bit clock.
module spi_ram_burst #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic SS_N,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic cmd_err
);
  localparam int MAXW  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CMD       = 3'd1;
  localparam logic [2:0] ADDR      = 3'd2;
  localparam logic [2:0] WRITE     = 3'd3;
  localparam logic [2:0] READ_TURN = 3'd4;
  localparam logic [2:0] READ      = 3'd5;
  localparam logic [2:0] IGNORE    = 3'd6;

  localparam logic [ADDR_WIDTH:0]   DEPTH_V  = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(MEM_DEPTH - 1);
  localparam logic [CNT_W-1:0]      ADDR_END = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0]      WORD_END = CNT_W'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [2:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic                  is_rd_q, is_rd_d;
  logic                  armed_q, armed_d;
  logic                  miso_q, miso_d;
  logic                  cmd_err_q, cmd_err_d;

  logic                  in_range, mem_we;
  logic [ADDR_WIDTH-1:0] ptr_nxt;
  logic [DATA_WIDTH-1:0] rd_word, wr_word;

  // Pointer wraps at the last real word; out-of-range pointers wrap naturally at 2**ADDR_WIDTH.
  assign in_range = {1'b0, ptr_q} < DEPTH_V;
  assign ptr_nxt  = (ptr_q == LAST_PTR) ? '0 : ptr_q + ADDR_WIDTH'(1);
  assign rd_word  = in_range ? mem[ptr_q[IDX_W-1:0]] : '0;
  assign wr_word  = {rx_q[DATA_WIDTH-2:0], MOSI};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    is_rd_d   = is_rd_q;
    armed_d   = armed_q | SS_N;
    cmd_err_d = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: if (!SS_N && armed_q) begin
        state_d = CMD;
        is_rd_d = MOSI;
        armed_d = 1'b0;
        cnt_d   = '0;
      end
      CMD: if (is_rd_q == MOSI) state_d = ADDR;
           else begin
             state_d   = IGNORE;
             cmd_err_d = 1'b1;
           end
      // The pointer doubles as the address shift register.
      ADDR: begin
        ptr_d = {ptr_q[ADDR_WIDTH-2:0], MOSI};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == ADDR_END) begin
          cnt_d   = '0;
          state_d = is_rd_q ? READ_TURN : WRITE;
        end
      end
      WRITE: begin
        rx_d  = wr_word;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == WORD_END) begin
          cnt_d  = '0;
          mem_we = in_range;
          ptr_d  = ptr_nxt;
        end
      end
      READ_TURN: begin
        tx_d    = rd_word;
        ptr_d   = ptr_nxt;
        cnt_d   = '0;
        state_d = READ;
      end
      READ: begin
        tx_d  = tx_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == WORD_END) begin
          tx_d  = rd_word;
          ptr_d = ptr_nxt;
          cnt_d = '0;
        end
      end
      IGNORE: ;
      default: state_d = IDLE;
    endcase
    // Abort: any partial word is dropped and the pointer keeps its pre-edge value.
    if (SS_N && state_q != IDLE) begin
      state_d   = IDLE;
      mem_we    = 1'b0;
      ptr_d     = ptr_q;
      cmd_err_d = 1'b0;
    end
    miso_d = (state_d == READ) ? tx_d[DATA_WIDTH-1] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      is_rd_q   <= 1'b0;
      armed_q   <= 1'b0;
      miso_q    <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      is_rd_q   <= is_rd_d;
      armed_q   <= armed_d;
      miso_q    <= miso_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem[ptr_q[IDX_W-1:0]] <= wr_word;
  end

  assign MISO    = miso_q;
  assign busy    = (state_q != IDLE);
  assign cmd_err = cmd_err_q;
endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: a default 8/8/256 instance and a 16/4/10 instance,
// read data checked against a queue of expected words.
module tb_spi_ram_burst;
  logic clk = 1'b0;
  logic rst;
  logic ss_n [2];
  logic mosi [2];
  logic miso [2];
  logic busy [2];
  logic cmd_err [2];
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  spi_ram_burst #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256)) u_a (
    .clk(clk), .rst(rst), .SS_N(ss_n[0]), .MOSI(mosi[0]),
    .MISO(miso[0]), .busy(busy[0]), .cmd_err(cmd_err[0]));

  spi_ram_burst #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .MEM_DEPTH(10)) u_b (
    .clk(clk), .rst(rst), .SS_N(ss_n[1]), .MOSI(mosi[1]),
    .MISO(miso[1]), .busy(busy[1]), .cmd_err(cmd_err[1]));

  function automatic int dw(int s); return (s == 0) ? 8 : 16; endfunction
  function automatic int aw(int s); return (s == 0) ? 8 : 4; endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(int s, logic b);
    ss_n[s] = 1'b0;
    mosi[s] = b;
    tick();
  endtask

  task automatic header(int s, logic [1:0] cmd, logic [31:0] addr);
    send_bit(s, cmd[1]);
    chk("busy_after_cycle0", 32'(busy[s]), 1);
    send_bit(s, cmd[0]);
    for (int i = aw(s) - 1; i >= 0; i--) send_bit(s, addr[i]);
  endtask

  task automatic end_frame(int s);
    ss_n[s] = 1'b1;
    mosi[s] = 1'b0;
    tick();
    chk("busy_after_ss_high", 32'(busy[s]), 0);
    chk("miso_after_ss_high", 32'(miso[s]), 0);
  endtask

  task automatic wr(int s, logic [31:0] addr, logic [31:0] words [$]);
    logic [31:0] w;
    header(s, 2'b00, addr);
    foreach (words[k]) begin
      w = words[k];
      for (int b = dw(s) - 1; b >= 0; b--) send_bit(s, w[b]);
    end
    end_frame(s);
  endtask

  // Expected words go to the scoreboard first, then are popped as each word shifts out.
  task automatic rd(int s, logic [31:0] addr, logic [31:0] words [$]);
    logic [31:0] got;
    foreach (words[k]) exp_q.push_back(words[k]);
    header(s, 2'b11, addr);
    send_bit(s, 1'b0);
    for (int k = 0; k < words.size(); k++) begin
      got = '0;
      for (int b = 0; b < dw(s); b++) begin
        got = {got[30:0], miso[s]};
        send_bit(s, 1'b0);
      end
      chk("read_word", got, exp_q.pop_front());
    end
    end_frame(s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int pulses;
    logic [7:0] pat;
    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      ss_n[s] = 1'b1;
      mosi[s] = 1'b0;
    end
    tick();
    tick();
    for (int s = 0; s < 2; s++) begin
      chk("reset_miso", 32'(miso[s]), 0);
      chk("reset_busy", 32'(busy[s]), 0);
      chk("reset_cmd_err", 32'(cmd_err[s]), 0);
    end
    rst = 1'b0;
    tick();

    // Single write/read; MISO bits start in the cycle after the turnaround edge.
    wr(0, 'h10, '{32'hA5});
    rd(0, 'h10, '{32'hA5});

    // Burst write across the top of memory, then burst read back.
    wr(0, 'hFE, '{32'h11, 32'h22, 32'h33});
    rd(0, 'hFE, '{32'h11, 32'h22, 32'h33});
    rd(0, 'h00, '{32'h33});

    // Illegal command: single cmd_err pulse, MISO silent, memory untouched.
    pulses = 0;
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    chk("cmd_err_pulse", 32'(cmd_err[0]), 1);
    pulses++;
    for (int i = 0; i < 20; i++) begin
      send_bit(0, 1'($urandom_range(0, 1)));
      chk("ignore_miso", 32'(miso[0]), 0);
      chk("ignore_busy", 32'(busy[0]), 1);
      if (cmd_err[0]) pulses++;
    end
    chk("cmd_err_pulse_count", 32'(pulses), 1);
    end_frame(0);
    rd(0, 'h10, '{32'hA5});

    // Abort mid-write leaves the old word in place.
    wr(0, 'h05, '{32'h00});
    header(0, 2'b00, 'h05);
    for (int i = 0; i < 5; i++) send_bit(0, 1'b1);
    end_frame(0);
    rd(0, 'h05, '{32'h00});

    // Abort mid-read: MISO returns to 0 on the abort edge.
    pat = 8'h11;
    header(0, 2'b11, 'hFE);
    send_bit(0, 1'b0);
    for (int b = 7; b > 3; b--) begin
      chk("partial_read_bit", 32'(miso[0]), 32'(pat[b]));
      send_bit(0, 1'b0);
    end
    end_frame(0);

    // Reset during a read word, then the word reads back unchanged.
    pat = 8'hA5;
    header(0, 2'b11, 'h10);
    send_bit(0, 1'b0);
    for (int b = 7; b > 4; b--) begin
      chk("pre_reset_bit", 32'(miso[0]), 32'(pat[b]));
      send_bit(0, 1'b0);
    end
    rst = 1'b1;
    tick();
    chk("reset_mid_read_miso", 32'(miso[0]), 0);
    chk("reset_mid_read_busy", 32'(busy[0]), 0);
    rst = 1'b0;
    ss_n[0] = 1'b1;
    tick();
    rd(0, 'h10, '{32'hA5});

    // Variant: 16-bit words, 4-bit address, 10-word memory.
    wr(1, 'h0, '{32'h5A5A});
    wr(1, 'h9, '{32'hBEEF});
    wr(1, 'hC, '{32'h1234});
    rd(1, 'h9, '{32'hBEEF});
    rd(1, 'hC, '{32'h0000});
    rd(1, 'h9, '{32'hBEEF, 32'h5A5A});
    rd(1, 'hF, '{32'h0000, 32'h5A5A});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Next-generation SPI-slave-plus-RAM block: parametrised data width, address width and depth.
- Adds burst transfers: address auto-increments while SS_N stays low.
- Integrates the serial front-end, FSM and single-port memory; sits at top level, driven directly by the SPI pins, with clk as the bit clock.
- Adds abort handling and an illegal-command flag.

Parameters:
DATA_WIDTH, 8, bits per memory word and per serial data word
ADDR_WIDTH, 8, bits in the serial address field and the internal address pointer
MEM_DEPTH, 256, number of words; must satisfy 1 <= MEM_DEPTH <= 2**ADDR_WIDTH

Ports:
clk  input  1  single clock; MOSI/SS_N sampled and all state updated on rising edge
rst  input  1  synchronous, active-high reset
SS_N  input  1  active-low slave select; low frames a transaction
MOSI  input  1  serial data in, MSB first
MISO  output  1  serial data out, MSB first; 0 when not in READ
busy  output  1  1 whenever FSM is not IDLE
cmd_err  output  1  one-cycle pulse on illegal command

Behaviour:
- Reset (rst=1 at rising edge): state=IDLE, MISO=0, busy=0, cmd_err=0, bit counter=0, address pointer=0. Memory contents are NOT cleared. Reset overrides everything, including mid-transaction.
- States: IDLE, CMD, ADDR, WRITE, READ_TURN, READ, IGNORE.
- Cycle numbering: cycle 0 = first rising edge with SS_N=0 seen in IDLE.
- IDLE:
  - SS_N=0 -> CMD; MOSI at cycle 0 is cmd bit 1.
- CMD:
  - Cycle 1 samples cmd bit 0.
  - cmd 2'b00 = WRITE burst; 2'b11 = READ burst -> ADDR.
  - 2'b01 or 2'b10 -> IGNORE, with cmd_err=1 for exactly the cycle after cycle 1.
- ADDR:
  - Cycles 2 .. 2+ADDR_WIDTH-1 shift in the address, MSB first.
  - At the last bit's edge the pointer loads the full address.
  - Then -> WRITE (cmd 00) or READ_TURN (cmd 11).
- WRITE:
  - Data words of DATA_WIDTH bits, MSB first, back to back.
  - On the edge sampling a word's last bit: mem[ptr] <= assembled word; ptr <= ptr+1.
  - If ptr=MEM_DEPTH-1, ptr wraps to 0.
  - If ptr >= MEM_DEPTH (possible only when MEM_DEPTH < 2**ADDR_WIDTH), the write is dropped and ptr still increments, wrapping to 0 at 2**ADDR_WIDTH-1 or MEM_DEPTH-1, whichever comes first.
- READ_TURN:
  - Exactly one cycle (cycle 2+ADDR_WIDTH); MOSI ignored.
  - At its edge: tx_shift <= mem[ptr] (0 if ptr >= MEM_DEPTH); ptr <= ptr+1 with the same wrap rule -> READ.
- READ:
  - MISO = tx_shift[DATA_WIDTH-1], registered; the first bit is valid during cycle 3+ADDR_WIDTH.
  - Each edge shifts left.
  - On the edge after a word's last bit is presented, tx_shift reloads mem[ptr] and ptr increments. Consecutive words follow with no gap.
  - MOSI ignored.
- IGNORE: hold until SS_N=1; MISO=0.
- Abort: SS_N=1 sampled in any non-IDLE state -> IDLE on that edge.
  - Partial write word discarded (no memory write).
  - Partial read word discarded; MISO=0 from the next cycle.
  - Pointer value retained but unused.
- SS_N high in IDLE: no action. A new transaction needs SS_N=1 for at least one edge before going low again.
- Memory: single port, one read or write per edge, never both; synchronous read.
- busy=1 from the edge leaving IDLE until the edge returning to IDLE.

Test Plan:
- Single write/read (DW=8, AW=8):
  - Frame 00, addr 0x10, data 0xA5, then SS_N high.
  - Frame 11, addr 0x10.
  - Expect MISO = 1,0,1,0,0,1,0,1 starting at cycle 11.
- Burst with wrap (MEM_DEPTH=256):
  - Write at 0xFE the data 0x11, 0x22, 0x33.
  - Burst read of 3 words from 0xFE returns 0x11, 0x22, 0x33; the last word is located at address 0x00.
- Illegal command:
  - cmd 01 followed by 20 arbitrary bits.
  - Expect cmd_err pulses exactly once for 1 cycle, memory unchanged, MISO=0 throughout, busy drops the edge after SS_N rises.
- Abort mid-write:
  - Write 00, addr 0x05, send 5 of 8 data bits of 0xFF, raise SS_N.
  - Read 0x05 returns its prior value (0x00 after power-up test preload).
- Reset mid-read:
  - Assert rst during bit 3 of a read word.
  - Expect MISO=0, busy=0 the next cycle.
  - A new read of the same address returns the unchanged stored word.
- Parameter variant (DW=16, AW=4, MEM_DEPTH=10):
  - Write 0xBEEF at 0x9, then write 0x1234 at 0xC.
  - Read 0x9 returns 0xBEEF; read 0xC returns 0x0000.
  - Burst from 0x9 wraps and returns mem[0] as its second word.
